mul_ctrl: RTL and testbench



---
 rtl/mul_pkg.sv | 56 +++++
 rtl/mul_iter_cnt.sv | 36 +++
 rtl/mul_ctrl.sv | 108 ++++++++++
 tb/tb_mul_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the repeated-addition multiplier controller:
//   - MUL_W        default datapath / operand width
//   - mul_state_t  3-bit binary controller state encoding
//   - mul_strobe_t bundle of the Moore outputs decoded from the state
//   - mul_decode() state -> strobe decode used by mul_ctrl
// -----------------------------------------------------------------------------
package mul_pkg;

    localparam int MUL_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CHECK  = 3'd3,
        ADD    = 3'd4,
        DONE   = 3'd5
    } mul_state_t;

    typedef struct packed {
        logic ld_a;
        logic ld_b;
        logic clr_p;
        logic ld_p;
        logic dec_b;
        logic done;
        logic busy;
    } mul_strobe_t;

    // Pure function of the state: the controller is a Moore machine, so no
    // input can reach a strobe combinationally.
    function automatic mul_strobe_t mul_decode(input mul_state_t s);
        mul_strobe_t o;
        o      = '0;
        o.busy = (s != IDLE);
        case (s)
            LOAD_A: o.ld_a = 1'b1;
            LOAD_B: begin
                o.ld_b  = 1'b1;
                o.clr_p = 1'b1;
            end
            ADD: begin
                // The add and the decrement always happen together, so the
                // next CHECK sees the decremented B.
                o.ld_p  = 1'b1;
                o.dec_b = 1'b1;
            end
            DONE:    o.done = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mul_iter_cnt.sv
// -----------------------------------------------------------------------------
// mul_iter_cnt
// W-bit iteration counter with synchronous clear and increment enable.
// Clear has priority over enable. Never wraps in use: the operand B that
// bounds the number of increments is itself W bits wide.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset (count -> 0)
//   clr    in   synchronous clear
//   en     in   increment enable
//   cnt    out  current count (W bits)
// -----------------------------------------------------------------------------
module mul_iter_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mul_ctrl.sv
// -----------------------------------------------------------------------------
// mul_ctrl
// Sequencing controller for a repeated-addition multiplier datapath
// (A register, down-counting B register with zero compare, P register, adder).
// On start it loads A then B from the shared bus (clearing P), then alternates
// CHECK / ADD until B reaches zero, then holds done until res_ready.
// Only control strobes are produced; data stays in the datapath.
//
// Configuration macro:
//   MUL_CTRL_ZERO_SKIP_EN  when defined, CHECK also finishes on eqa (A==0),
//                          so a zero multiplicand costs no iterations. When
//                          undefined, eqa is ignored (port kept).
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   start      in   start request, sampled only in IDLE
//   eqz        in   datapath B==0, sampled only in CHECK
//   eqa        in   datapath A==0, used only with the zero-skip macro
//   res_ready  in   consumer accepts the product while done is high
//   ldA        out  load A from bus
//   ldB        out  load B from bus
//   clrP       out  clear P
//   ldP        out  P <= P + A
//   decB       out  B <= B - 1
//   busy       out  high in every state except IDLE
//   done       out  product valid in P
//   iter_cnt   out  adds performed in the current/last operation
// -----------------------------------------------------------------------------
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         eqz,
    input  logic         eqa,
    input  logic         res_ready,
    output logic         ldA,
    output logic         ldB,
    output logic         clrP,
    output logic         ldP,
    output logic         decB,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] iter_cnt
);

    mul_state_t  state;
    mul_state_t  state_nxt;
    mul_strobe_t strb;
    logic        finish;

`ifdef MUL_CTRL_ZERO_SKIP_EN
    assign finish = eqz | eqa;
`else
    logic unused_eqa;
    assign finish     = eqz;
    assign unused_eqa = eqa;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD_A;
            LOAD_A:  state_nxt = LOAD_B;
            LOAD_B:  state_nxt = CHECK;
            CHECK:   state_nxt = finish ? DONE : ADD;
            ADD:     state_nxt = CHECK;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign strb = mul_decode(state);
    assign ldA  = strb.ld_a;
    assign ldB  = strb.ld_b;
    assign clrP = strb.clr_p;
    assign ldP  = strb.ld_p;
    assign decB = strb.dec_b;
    assign busy = strb.busy;
    assign done = strb.done;

    // Cleared while B is loaded so the count restarts for each operation,
    // then bumped once per ADD; it holds through DONE and IDLE.
    mul_iter_cnt #(
        .W (W)
    ) u_iter_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == LOAD_B),
        .en    (state == ADD),
        .cnt   (iter_cnt)
    );

endmodule

// File: tb/tb_mul_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_ctrl
// Scoreboarded bench for mul_ctrl. A small behavioural datapath (A, B, P)
// reacts to the controller strobes. The driver pushes one expected record
// per started operation; the monitor, on every falling edge, derives the
// expected strobes and iter_cnt from the cycle offset within that record,
// checks P on the first done cycle, and retires the record on acceptance.
// -----------------------------------------------------------------------------
module tb_mul_ctrl;
    import mul_pkg::*;

    localparam int W = MUL_W;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         start     = 1'b0;
    logic         res_ready = 1'b0;
    logic         eqz;
    logic         eqa;
    logic         ldA, ldB, clrP, ldP, decB, busy, done;
    logic [W-1:0] iter_cnt;

    logic [W-1:0] bus = '0;
    logic [W-1:0] ra  = '0;
    logic [W-1:0] rb  = '0;
    logic [W-1:0] rp  = '0;

    int           cyc     = 0;
    int           n_vec   = 0;
    int           n_bad   = 0;
    bit           armed   = 1'b0;
    logic [W-1:0] exp_cnt = '0;

    typedef struct {
        int           issue;
        int           done_cyc;
        logic [W-1:0] p;
        logic [W-1:0] n;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mul_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .eqz       (eqz),
        .eqa       (eqa),
        .res_ready (res_ready),
        .ldA       (ldA),
        .ldB       (ldB),
        .clrP      (clrP),
        .ldP       (ldP),
        .decB      (decB),
        .busy      (busy),
        .done      (done),
        .iter_cnt  (iter_cnt)
    );

    // Behavioural datapath driven by the strobes
    assign eqz = (rb == '0);
    assign eqa = (ra == '0);

    always @(posedge clk) begin
        if (ldA) ra <= bus;
        if (ldB) rb <= bus;
        else if (decB) rb <= rb - 1'b1;
        if (clrP) rp <= '0;
        else if (ldP) rp <= rp + ra;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: strobe order {ldA, ldB, clrP, ldP, decB, done, busy}
    always @(negedge clk) begin : mon
        logic [6:0]   es;
        logic [W-1:0] ec;
        int           c;
        if (armed) begin
            es = '0;
            ec = exp_cnt;
            c  = 0;
            if (sb.size() != 0) begin
                c     = cyc - sb[0].issue + 1;
                es[0] = 1'b1;
                if (c == 1) es[6] = 1'b1;
                else if (c == 2) begin
                    es[5] = 1'b1;
                    es[4] = 1'b1;
                end else if (c >= sb[0].done_cyc) es[1] = 1'b1;
                else if (c >= 4 && (c % 2) == 0) begin
                    es[3] = 1'b1;
                    es[2] = 1'b1;
                end
                if (c >= 3) ec = (c >= sb[0].done_cyc) ? sb[0].n : W'((c - 3) / 2);
            end
            check("strobes", {25'd0, ldA, ldB, clrP, ldP, decB, done, busy}, {25'd0, es});
            check("iter_cnt", {16'd0, iter_cnt}, {16'd0, ec});
            if (sb.size() != 0 && es[1]) begin
                if (c == sb[0].done_cyc) check("product", {16'd0, rp}, {16'd0, sb[0].p});
                if (res_ready) begin
                    exp_cnt = sb[0].n;
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Start an operation (edge 0), feed A/B on the bus, then accept after
    // 'hold' extra done cycles; with poke, start toggles while done waits.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit poke);
        exp_t e;
        int   k;
        @(posedge clk); #1;
        start = 1'b1;
        if (hold == 0) res_ready = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        bus     = a;
        e.issue = cyc;
`ifdef MUL_CTRL_ZERO_SKIP_EN
        e.n = (a == '0) ? '0 : b;
`else
        e.n = b;
`endif
        e.done_cyc = 4 + 2 * int'(e.n);
        e.p        = a * b;
        sb.push_back(e);
        @(posedge clk); #1;
        bus = b;
        k   = 0;
        while (done !== 1'b1 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (done !== 1'b1) begin
            check("done_timeout", {31'd0, done}, 32'd1);
            sb.delete();
            res_ready = 1'b0;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (poke) start = (i % 2 == 0);
        end
        res_ready = 1'b1;
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        start     = 1'b0;
    endtask

    // Start an operation and pull rst_n low during cycle 'at_cycle', so the
    // reset lands on the edge that ends that cycle.
    task automatic reset_mid(input logic [W-1:0] a, input logic [W-1:0] b, input int at_cycle);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        bus        = a;
        e.issue    = cyc;
        e.n        = b;
        e.done_cyc = 4 + 2 * int'(b);
        e.p        = a * b;
        sb.push_back(e);
        repeat (at_cycle - 1) @(posedge clk);
        #1;
        if (cyc - e.issue + 1 == 2) bus = b;
        rst_n = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        exp_cnt = '0;
        rst_n   = 1'b1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_cnt", {16'd0, iter_cnt}, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        armed = 1'b1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_outs", {25'd0, ldA, ldB, clrP, ldP, decB, done, busy}, 32'd0);
        check("rst_cnt", {16'd0, iter_cnt}, 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);

        run_op(16'd5, 16'd3, 0, 1'b0);  // done in cycle 10, P=15
        run_op(16'd7, 16'd0, 0, 1'b0);  // done in cycle 4, no ldP
        run_op(16'd2, 16'd2, 5, 1'b1);  // backpressure with ignored starts
        repeat (2) @(posedge clk);

        // Bring B into the bus during cycle 2 before the mid-op reset
        fork
            reset_mid(16'd4, 16'd5, 6);
            begin
                repeat (3) @(posedge clk);
                #2;
                bus = 16'd5;
            end
        join
        run_op(16'd3, 16'd2, 0, 1'b0);  // P=6, iter_cnt=2
        run_op(16'd0, 16'd5, 0, 1'b0);  // zero multiplicand
        run_op(16'd1, 16'd1, 0, 1'b0);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
